// File: rtl/event_sequence_fsm.sv
`default_nettype none
// ============================================================================
// event_sequence_fsm : ordered-event sequencer with timeout and strict abort
// Rev 1.0
// ============================================================================
module event_sequence_fsm #(
  parameter int N_STEPS   = 4,
  parameter int TIMEOUT_W = 8,
  parameter bit STICKY    = 1'b1,
  parameter bit STRICT    = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               en,
  input  logic [N_STEPS-1:0]                 ev,
  input  logic [TIMEOUT_W-1:0]               timeout_lim,
  output logic [$clog2(N_STEPS+1)-1:0]       step,
  output logic                               done,
  output logic                               done_pulse,
  output logic                               err,
  output logic [1:0]                         err_code
);

  localparam int SW = $clog2(N_STEPS + 1);

  localparam logic [SW-1:0]        c_ST_WAIT0    = '0;
  localparam logic [SW-1:0]        c_ST_DONE     = SW'(N_STEPS);
  localparam logic [SW-1:0]        c_ST_ONE      = SW'(1);
  localparam logic [1:0]           c_ERR_ORDER   = 2'b01;
  localparam logic [1:0]           c_ERR_TIMEOUT = 2'b10;
  localparam logic [TIMEOUT_W-1:0] c_TMR_ONE     = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] c_TMR_MAX     = '1;
  localparam logic [N_STEPS-1:0]   c_EV_LSB      = N_STEPS'(1);

  logic [SW-1:0]        r_state;
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic                 r_done_pulse;

  logic [SW-1:0]        w_state_nxt;
  logic [TIMEOUT_W-1:0] w_timer_nxt;
  logic                 w_err_nxt;
  logic [1:0]           w_err_code_nxt;
  logic                 w_done_pulse_nxt;

  logic [N_STEPS-1:0]   w_onehot;
  logic                 w_ev_exp;
  logic                 w_ev_wrong;
  logic                 w_tmo_hit;

  // The expected event is the bit selected by the current step; DONE selects none.
  assign w_onehot   = c_EV_LSB << r_state;
  assign w_ev_exp   = |(ev & w_onehot);
  assign w_ev_wrong = |(ev & ~w_onehot);
  assign w_tmo_hit  = (r_timer == (timeout_lim - c_TMR_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_WAIT0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_done_pulse <= w_done_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    if (clr) begin
      w_state_nxt = c_ST_WAIT0;
      w_timer_nxt = '0;
    end else if (r_state == c_ST_DONE) begin
      // Pulse mode leaves DONE on the very next edge, even with en low.
      if (!STICKY) begin
        w_state_nxt = c_ST_WAIT0;
      end
      w_timer_nxt = '0;
    end else if (en) begin
      if (w_ev_exp) begin
        w_state_nxt = r_state + c_ST_ONE;
        w_timer_nxt = '0;
      end else if (STRICT && w_ev_wrong) begin
        w_state_nxt    = c_ST_WAIT0;
        w_timer_nxt    = '0;
        w_err_nxt      = 1'b1;
        w_err_code_nxt = c_ERR_ORDER;
      end else if ((r_state != c_ST_WAIT0) && (timeout_lim != '0)) begin
        if (w_tmo_hit) begin
          w_state_nxt    = c_ST_WAIT0;
          w_timer_nxt    = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = c_ERR_TIMEOUT;
        end else if (r_timer != c_TMR_MAX) begin
          w_timer_nxt = r_timer + c_TMR_ONE;
        end
      end
    end
    w_done_pulse_nxt = (w_state_nxt == c_ST_DONE) && (r_state != c_ST_DONE);
  end

  always_comb begin
    step       = r_state;
    done       = (r_state == c_ST_DONE);
    done_pulse = r_done_pulse;
    err        = r_err;
    err_code   = r_err_code;
  end

endmodule
`default_nettype wire

// File: tb/tb_event_sequence_fsm.sv
`default_nettype none
// ============================================================================
// tb_event_sequence_fsm : directed and randomized checks of event_sequence_fsm
// Rev 1.0
// ============================================================================
module tb_event_sequence_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] ev  = '0;
  logic [7:0] lim = '0;

  // a: 4 steps strict sticky, b: 4 steps lenient pulse-mode, c: 2 steps sticky
  logic [2:0] step_a, step_b;
  logic [1:0] step_c;
  logic       done_a, done_b, done_c, dp_a, dp_b, dp_c, err_a, err_b, err_c;
  logic [1:0] code_a, code_b, code_c;

  event_sequence_fsm #(.N_STEPS(4), .TIMEOUT_W(8), .STICKY(1'b1), .STRICT(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .ev(ev), .timeout_lim(lim),
    .step(step_a), .done(done_a), .done_pulse(dp_a), .err(err_a), .err_code(code_a));
  event_sequence_fsm #(.N_STEPS(4), .TIMEOUT_W(8), .STICKY(1'b0), .STRICT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .ev(ev), .timeout_lim(lim),
    .step(step_b), .done(done_b), .done_pulse(dp_b), .err(err_b), .err_code(code_b));
  event_sequence_fsm #(.N_STEPS(2), .TIMEOUT_W(8), .STICKY(1'b1), .STRICT(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .ev(ev[1:0]), .timeout_lim(lim),
    .step(step_c), .done(done_c), .done_pulse(dp_c), .err(err_c), .err_code(code_c));

  always #5 clk = ~clk;

  wire [7:0] obs_a = {step_a, done_a, dp_a, err_a, code_a};
  wire [7:0] obs_b = {step_b, done_b, dp_b, err_b, code_b};
  wire [7:0] obs_c = {1'b0, step_c, done_c, dp_c, err_c, code_c};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: position in the sequence plus count of waiting enabled cycles.
  typedef struct {
    int       pos;
    int       t;
    bit       err;
    bit [1:0] code;
    bit       pulse;
  } m_t;

  m_t ma, mb, mc;

  function automatic m_t model_reset();
    m_t r;
    r.pos = 0; r.t = 0; r.err = 0; r.code = 2'b00; r.pulse = 0;
    return r;
  endfunction

  function automatic m_t model_next(m_t m, int n, bit sticky, bit strict,
                                    bit c, bit e, logic [3:0] evv, logic [7:0] l);
    m_t r = m;
    bit other = 0;
    r.err = 0;
    r.pulse = 0;
    if (c) begin
      r.pos = 0; r.t = 0;
    end else if (m.pos == n) begin
      if (!sticky) r.pos = 0;
      r.t = 0;
    end else if (e) begin
      for (int j = 0; j < n; j++) if (j != m.pos && evv[j]) other = 1;
      if (evv[m.pos]) begin
        r.pos = m.pos + 1; r.t = 0; r.pulse = (r.pos == n);
      end else if (strict && other) begin
        r.pos = 0; r.t = 0; r.err = 1; r.code = 2'b01;
      end else if (m.pos > 0 && l != 0) begin
        if (m.t + 1 == int'(l)) begin
          r.pos = 0; r.t = 0; r.err = 1; r.code = 2'b10;
        end else if (m.t < 255) begin
          r.t = m.t + 1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] pack(m_t m, int n);
    return {3'(m.pos), (m.pos == n), m.pulse, m.err, m.code};
  endfunction

  // Apply inputs for one edge, advance all three reference models, settle.
  task automatic cyc(input bit c, input bit e, input logic [3:0] evv);
    clr = c; en = e; ev = evv;
    @(posedge clk);
    ma = model_next(ma, 4, 1'b1, 1'b1, c, e, evv, lim);
    mb = model_next(mb, 4, 1'b0, 1'b0, c, e, evv, lim);
    mc = model_next(mc, 2, 1'b1, 1'b0, c, e, {2'b00, evv[1:0]}, lim);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    n_checks++; if (obs_a !== 8'h00) begin n_fail++; $display("FAIL reset_a: got %h want 00", obs_a); end
    n_checks++; if (obs_b !== 8'h00) begin n_fail++; $display("FAIL reset_b: got %h want 00", obs_b); end
    n_checks++; if (obs_c !== 8'h00) begin n_fail++; $display("FAIL reset_c: got %h want 00", obs_c); end
    rst = 1'b0;
  endtask

  task automatic test_two_step();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0001);
    n_checks++; if (obs_c !== 8'b0_01_0_0_0_00) begin n_fail++; $display("FAIL two_step_s1: got %b want 00100000", obs_c); end
    cyc(0, 1, 4'b0010);
    n_checks++; if (obs_c !== 8'b0_10_1_1_0_00) begin n_fail++; $display("FAIL two_step_done: got %b want 01011000", obs_c); end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 4'($urandom));
      n_checks++;
      if (!(done_c === 1'b1 && dp_c === 1'b0 && step_c === 2'd2)) begin
        n_fail++; $display("FAIL two_step_hold: cycle %0d got %b want done held", i, obs_c);
      end
      n_checks++;
      if (obs_c !== pack(mc, 2)) begin n_fail++; $display("FAIL two_step_model: got %h want %h", obs_c, pack(mc, 2)); end
    end
  endtask

  task automatic test_strict_abort();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0001);
    cyc(0, 1, 4'b0010);
    n_checks++; if (step_a !== 3'd2) begin n_fail++; $display("FAIL strict_setup: got %0d want 2", step_a); end
    cyc(0, 1, 4'b0001);
    n_checks++;
    if (!(step_a === 3'd0 && err_a === 1'b1 && code_a === 2'b01)) begin
      n_fail++; $display("FAIL strict_abort: got step=%0d err=%b code=%b want 0/1/01", step_a, err_a, code_a);
    end
    n_checks++; if (step_b !== 3'd2) begin n_fail++; $display("FAIL lenient_ignore: got %0d want 2", step_b); end
    cyc(0, 1, 4'b0000);
    n_checks++;
    if (!(err_a === 1'b0 && code_a === 2'b01)) begin
      n_fail++; $display("FAIL strict_err_len: got err=%b code=%b want 0/01", err_a, code_a);
    end
    cyc(0, 1, 4'b0001);
    cyc(0, 1, 4'b0010);
    cyc(0, 1, 4'b0101);
    n_checks++;
    if (!(step_a === 3'd3 && err_a === 1'b0)) begin
      n_fail++; $display("FAIL strict_advance_wins: got step=%0d err=%b want 3/0", step_a, err_a);
    end
  endtask

  task automatic test_timeout();
    lim = 8'd5;
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0001);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 4'b0000);
      n_checks++;
      if (i < 5 && !(step_a === 3'd1 && err_a === 1'b0)) begin
        n_fail++; $display("FAIL timeout_wait: cycle %0d got step=%0d err=%b want 1/0", i, step_a, err_a);
      end else if (i == 5 && !(step_a === 3'd0 && err_a === 1'b1 && code_a === 2'b10)) begin
        n_fail++; $display("FAIL timeout_abort: got step=%0d err=%b code=%b want 0/1/10", step_a, err_a, code_a);
      end
    end
    cyc(0, 1, 4'b0001);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, i[0], 4'b0000);
      n_checks++;
      if (i < 9 && !(step_a === 3'd1 && err_a === 1'b0)) begin
        n_fail++; $display("FAIL timeout_en_wait: cycle %0d got step=%0d err=%b want 1/0", i, step_a, err_a);
      end else if (i == 9 && !(step_a === 3'd0 && err_a === 1'b1 && code_a === 2'b10)) begin
        n_fail++; $display("FAIL timeout_en_abort: got step=%0d err=%b code=%b want 0/1/10", step_a, err_a, code_a);
      end
    end
    lim = 8'd0;
  endtask

  task automatic test_pulse_mode();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    for (int rep = 0; rep < 2; rep++) begin
      cyc(0, 1, 4'b0001);
      cyc(0, 1, 4'b0010);
      cyc(0, 1, 4'b0100);
      cyc(0, 1, 4'b1000);
      n_checks++;
      if (!(step_b === 3'd4 && done_b === 1'b1 && dp_b === 1'b1)) begin
        n_fail++; $display("FAIL pulse_done: pass %0d got step=%0d done=%b dp=%b want 4/1/1", rep, step_b, done_b, dp_b);
      end
      cyc(0, 0, 4'b0000);
      n_checks++;
      if (!(step_b === 3'd0 && done_b === 1'b0 && dp_b === 1'b0)) begin
        n_fail++; $display("FAIL pulse_return: pass %0d got step=%0d done=%b dp=%b want 0/0/0", rep, step_b, done_b, dp_b);
      end
    end
  endtask

  task automatic test_clr_final();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0001);
    cyc(0, 1, 4'b0010);
    cyc(0, 1, 4'b0100);
    cyc(1, 1, 4'b1000);
    n_checks++;
    if (!(step_a === 3'd0 && done_a === 1'b0 && err_a === 1'b0)) begin
      n_fail++; $display("FAIL clr_final: got step=%0d done=%b err=%b want 0/0/0", step_a, done_a, err_a);
    end
    cyc(0, 1, 4'b0000);
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL clr_final_hold: got done=%b want 0", done_a); end
  endtask

  task automatic test_async_reset();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    cyc(0, 1, 4'b0001);
    cyc(0, 1, 4'b0010);
    cyc(0, 1, 4'b0100);
    n_checks++; if (step_a !== 3'd3) begin n_fail++; $display("FAIL async_setup: got %0d want 3", step_a); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (obs_a !== 8'h00) begin n_fail++; $display("FAIL async_rst_a: got %h want 00", obs_a); end
    n_checks++; if (obs_b !== 8'h00) begin n_fail++; $display("FAIL async_rst_b: got %h want 00", obs_b); end
    n_checks++; if (obs_c !== 8'h00) begin n_fail++; $display("FAIL async_rst_c: got %h want 00", obs_c); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ma = model_reset(); mb = model_reset(); mc = model_reset();
  endtask

  task automatic test_back_to_back();
    lim = 8'd0;
    cyc(1, 1, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 4'b1111);
      n_checks++;
      if (!(step_a === 3'(i) && err_a === 1'b0 && done_a === (i == 4) && dp_a === (i == 4))) begin
        n_fail++; $display("FAIL back_to_back: cycle %0d got step=%0d err=%b done=%b dp=%b", i, step_a, err_a, done_a, dp_a);
      end
      n_checks++;
      if (obs_b !== pack(mb, 4)) begin n_fail++; $display("FAIL back_to_back_b: got %h want %h", obs_b, pack(mb, 4)); end
    end
  endtask

  task automatic test_random();
    logic [3:0] evv;
    logic [7:0] lims [5] = '{8'd0, 8'd2, 8'd3, 8'd5, 8'd7};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) lim = lims[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0:       evv = 4'b0000;
        1:       evv = 4'($urandom);
        default: evv = 4'b0001 << $urandom_range(0, 3);
      endcase
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), evv);
      n_checks++; if (obs_a !== pack(ma, 4)) begin n_fail++; $display("FAIL random_a: cycle %0d got %h want %h", i, obs_a, pack(ma, 4)); end
      n_checks++; if (obs_b !== pack(mb, 4)) begin n_fail++; $display("FAIL random_b: cycle %0d got %h want %h", i, obs_b, pack(mb, 4)); end
      n_checks++; if (obs_c !== pack(mc, 2)) begin n_fail++; $display("FAIL random_c: cycle %0d got %h want %h", i, obs_c, pack(mc, 2)); end
    end
  endtask

  initial begin
    test_reset();
    test_two_step();
    test_strict_abort();
    test_timeout();
    test_pulse_mode();
    test_clr_final();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
